// File: rtl/dcm_pkg.sv
// Shared types for the duty-cycle meter.
// Measurement FSM states and default counter width.
package dcm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Output is the last flop of the chain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/duty_cycle_meter.sv
// Measures period and high time of an async clock-like input
// in sampling-clock cycles, with stuck-high/low detection.
module duty_cycle_meter
  import dcm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic               w_sig_s;
  logic               r_sig_d;
  logic [SYNC_STAGES:0] r_warm;
  logic               w_armed;
  logic               w_rise;
  logic               w_fall;
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_hi_tmp;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .q    (w_sig_s)
  );

  // Edges are ignored until the pipeline has flushed its reset
  // zeros, so a signal already high at reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_d <= 1'b0;
      r_warm  <= '0;
    end else begin
      r_sig_d <= w_sig_s;
      r_warm  <= {r_warm[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_armed = r_warm[SYNC_STAGES];
  assign w_rise  = w_armed & w_sig_s & ~r_sig_d;
  assign w_fall  = w_armed & ~w_sig_s & r_sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hi_tmp   <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (!meas_en) begin
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_hi_tmp   <= '0;
        stuck_high <= 1'b0;
        stuck_low  <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_state <= WAIT_RISE;
            r_cnt   <= '0;
          end
          WAIT_RISE: begin
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_state <= MEAS_HIGH;
            end else if (r_cnt == CNT_MAX) begin
              stuck_low <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          MEAS_HIGH: begin
            if (r_cnt == CNT_MAX) begin
              stuck_high <= 1'b1;
              r_cnt      <= '0;
              r_state    <= WAIT_RISE;
            end else if (w_fall) begin
              r_hi_tmp <= r_cnt;
              r_cnt    <= r_cnt + 1'b1;
              r_state  <= MEAS_LOW;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          MEAS_LOW: begin
            if (r_cnt == CNT_MAX) begin
              stuck_low <= 1'b1;
              r_cnt     <= '0;
              r_state   <= WAIT_RISE;
            end else if (w_rise) begin
              period_cnt <= r_cnt;
              high_cnt   <= r_hi_tmp;
              meas_valid <= 1'b1;
              stuck_high <= 1'b0;
              stuck_low  <= 1'b0;
              r_cnt      <= CNT_ONE;
              r_state    <= MEAS_HIGH;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
